// File: rtl/aes_pkg.sv
// aes_pkg: shared AES datapath widths, queue depth and the key-length to round-count helper.
package aes_pkg;
    localparam int AES_BLOCK_W    = 128;
    localparam int AES_WORD_W     = 32;
    localparam int AES_FIFO_DEPTH = 2;

    function automatic int aes_nr(input int nk);
        return nk == 8 ? 14 : nk == 6 ? 12 : 10;
    endfunction
endpackage

// File: rtl/aes_blk_fifo2.sv
// aes_blk_fifo2: two-entry block+pad queue kept as a shift register so the head is always entry 0.
module aes_blk_fifo2
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [AES_BLOCK_W:0] din_i,
    output logic [AES_BLOCK_W:0] dout_o,
    output logic [1:0]           count_o,
    output logic                 full_o,
    output logic                 empty_o
);
    logic [AES_BLOCK_W:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]           count_q, count_d;
    logic                 wr0, wr1;

    always_comb begin
        wr0     = push_i && (count_q == 2'd0 || (count_q == 2'd1 && pop_i));
        wr1     = push_i && ((count_q == 2'd1 && !pop_i) || (count_q == 2'd2 && pop_i));
        e0_d    = wr0 ? din_i : pop_i ? e1_q : e0_q;
        e1_d    = wr1 ? din_i : e1_q;
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= '0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign dout_o  = e0_q;
    assign count_o = count_q;
    assign full_o  = count_q == 2'(AES_FIFO_DEPTH);
    assign empty_o = count_q == 2'd0;
endmodule

// File: rtl/aes_block_assembler.sv
// aes_block_assembler: packs 32-bit plaintext words into 128-bit blocks queued for the AES core.
// Define AES_ASM_KEY_EN to load the key through the key_data stream instead of the static key_in.
module aes_block_assembler
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [AES_WORD_W-1:0]   in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
`ifdef AES_ASM_KEY_EN
    input  logic [AES_WORD_W-1:0]   key_data,
    input  logic                    key_valid,
    output logic                    key_ready,
`else
    input  logic [NK*32-1:0]        key_in,
`endif
    output logic [NK*32-1:0]        key_out,
    output logic [AES_BLOCK_W-1:0]  blk_out,
    output logic                    blk_pad,
    output logic                    blk_valid,
    input  logic                    blk_ready
);
    if (NR != aes_nr(NK)) begin : g_bad_nr
        $error("NR does not match NK");
    end

    logic [1:0]              wcnt_q, wcnt_d;
    logic [AES_BLOCK_W-33:0] asm_q;
    logic [AES_BLOCK_W-1:0]  blk_w;
    logic                    acc, done, pad, full, empty, key_loaded;
    logic [1:0]              unused_count;

    // Lanes below wcnt come from the assembly register, the current word lands in lane wcnt, the rest are zero.
    always_comb begin
        acc    = in_valid && in_ready;
        done   = acc && (wcnt_q == 2'd3 || in_last);
        pad    = in_last && wcnt_q != 2'd3;
        wcnt_d = done ? 2'd0 : wcnt_q + 2'd1;
        blk_w  = ({asm_q, {AES_WORD_W{1'b0}}} & ~({AES_BLOCK_W{1'b1}} >> (AES_WORD_W * wcnt_q)))
               | ({in_data, {(AES_BLOCK_W - AES_WORD_W){1'b0}}} >> (AES_WORD_W * wcnt_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q <= '0;
            asm_q  <= '0;
        end else if (acc) begin
            wcnt_q <= wcnt_d;
            asm_q  <= blk_w[AES_BLOCK_W-1:AES_WORD_W];
        end
    end

    assign in_ready  = !(full && (wcnt_q == 2'd3 || (in_last && in_valid)));
    assign blk_valid = !empty && key_loaded;

    aes_blk_fifo2 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (done),
        .pop_i   (blk_valid && blk_ready),
        .din_i   ({pad, blk_w}),
        .dout_o  ({blk_pad, blk_out}),
        .count_o (unused_count),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef AES_ASM_KEY_EN
    logic [NK*32-1:0] key_q;
    logic [2:0]       kcnt_q;
    logic             loaded_q;

    // Key changes only while nothing is queued or partially assembled.
    assign key_ready = empty && wcnt_q == 2'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q    <= '0;
            kcnt_q   <= '0;
            loaded_q <= 1'b0;
        end else if (key_valid && key_ready) begin
            key_q    <= {key_q[NK*32-33:0], key_data};
            kcnt_q   <= kcnt_q == 3'(NK - 1) ? 3'd0 : kcnt_q + 3'd1;
            loaded_q <= kcnt_q == 3'(NK - 1);
        end
    end

    assign key_out    = key_q;
    assign key_loaded = loaded_q;
`else
    assign key_out    = key_in;
    assign key_loaded = 1'b1;
`endif
endmodule

// File: tb/tb_aes_block_assembler.sv
// tb_aes_block_assembler: directed checks of packing, padding, queueing, reset and key handling.
module tb_aes_block_assembler;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [127:0] key_out;
    logic [127:0] blk_out;
    logic         blk_pad;
    logic         blk_valid;
    logic         blk_ready = 1'b1;
    logic [127:0] key_val = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef AES_ASM_KEY_EN
    logic [31:0]  key_data = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
`else
    logic [127:0] key_in = 128'h000102030405060708090a0b0c0d0e0f;
`endif
    int n_checks = 0;
    int n_fail = 0;

    aes_block_assembler #(.NK(4), .NR(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
`ifdef AES_ASM_KEY_EN
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_ready (key_ready),
`else
        .key_in    (key_in),
`endif
        .key_out   (key_out),
        .blk_out   (blk_out),
        .blk_pad   (blk_pad),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

`ifdef AES_ASM_KEY_EN
    task automatic load_key(input int n);
        for (int i = 0; i < n; i++) begin
            key_data  = key_val[127-32*i -: 32];
            key_valid = 1'b1;
            tick();
        end
        key_valid = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_blk_valid", 128'(blk_valid), 128'd0);
        check("rst_blk_out", blk_out, 128'd0);
        check("rst_blk_pad", 128'(blk_pad), 128'd0);
`ifdef AES_ASM_KEY_EN
        check("rst_key_ready", 128'(key_ready), 128'd1);
        check("rst_key_out", key_out, 128'd0);
        load_key(4);
`endif
        check("key_out", key_out, key_val);

        send(32'h00112233, 1'b0);
        send(32'h44556677, 1'b0);
        send(32'h8899aabb, 1'b0);
        send(32'hccddeeff, 1'b0);
        check("full_valid", 128'(blk_valid), 128'd1);
        check("full_blk", blk_out, 128'h00112233445566778899aabbccddeeff);
        check("full_pad", 128'(blk_pad), 128'd0);
        tick();
        check("full_popped", 128'(blk_valid), 128'd0);

        send(32'hdeadbeef, 1'b0);
        send(32'h01234567, 1'b1);
        check("short_valid", 128'(blk_valid), 128'd1);
        check("short_blk", blk_out, 128'hdeadbeef012345670000000000000000);
        check("short_pad", 128'(blk_pad), 128'd1);
        check("short_wcnt", 128'(dut.wcnt_q), 128'd0);
        tick();

        send(32'haabbccdd, 1'b1);
        check("last0_blk", blk_out, 128'haabbccdd000000000000000000000000);
        check("last0_pad", 128'(blk_pad), 128'd1);
        tick();
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b0);
        send(32'h33333333, 1'b0);
        send(32'h44444444, 1'b1);
        check("last3_blk", blk_out, 128'h11111111222222223333333344444444);
        check("last3_pad", 128'(blk_pad), 128'd0);
        tick();

        blk_ready = 1'b0;
        for (int i = 1; i <= 11; i++) send(32'h10000000 + 32'(i), 1'b0);
`ifdef AES_ASM_KEY_EN
        check("queued_key_ready", 128'(key_ready), 128'd0);
`endif
        in_data  = 32'h1000000c;
        in_valid = 1'b1;
        #1;
        check("q_in_ready_low", 128'(in_ready), 128'd0);
        check("q_wcnt", 128'(dut.wcnt_q), 128'd3);
        check("q_head_a", blk_out, 128'h10000001100000021000000310000004);
        blk_ready = 1'b1;
        tick();
        check("q_in_ready_back", 128'(in_ready), 128'd1);
        check("q_head_b", blk_out, 128'h10000005100000061000000710000008);
        tick();
        in_valid = 1'b0;
        check("q_c_valid", 128'(blk_valid), 128'd1);
        check("q_head_c", blk_out, 128'h100000091000000a1000000b1000000c);
        check("q_c_pad", 128'(blk_pad), 128'd0);
        tick();
        check("q_drained", 128'(blk_valid), 128'd0);

        blk_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(32'h55550000 + 32'(i), 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 128'(blk_valid), 128'd0);
        check("mid_rst_in_ready", 128'(in_ready), 128'd1);
        check("mid_rst_blk", blk_out, 128'd0);
        check("mid_rst_wcnt", 128'(dut.wcnt_q), 128'd0);
        reset = 1'b0;
        blk_ready = 1'b1;
`ifdef AES_ASM_KEY_EN
        load_key(4);
`endif
        send(32'ha0a0a0a0, 1'b0);
        send(32'hb1b1b1b1, 1'b0);
        send(32'hc2c2c2c2, 1'b0);
        send(32'hd3d3d3d3, 1'b0);
        check("clean_valid", 128'(blk_valid), 128'd1);
        check("clean_blk", blk_out, 128'ha0a0a0a0b1b1b1b1c2c2c2c2d3d3d3d3);
        check("clean_pad", 128'(blk_pad), 128'd0);
        tick();

`ifdef AES_ASM_KEY_EN
        do_reset();
        load_key(3);
        send(32'h01010101, 1'b0);
        send(32'h02020202, 1'b0);
        send(32'h03030303, 1'b0);
        send(32'h04040404, 1'b0);
        check("nokey_valid", 128'(blk_valid), 128'd0);
        check("nokey_key_ready", 128'(key_ready), 128'd0);
        do_reset();
        load_key(4);
        check("reload_key_out", key_out, key_val);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_block_assembler.md
# aes_block_assembler

Upstream feeder for the iterative AES encrypt core. It takes 32-bit plaintext words from a valid/ready stream and packs them into 128-bit blocks. It buffers up to two completed blocks so the next block can assemble while the core is busy, and presents the cipher key for the whole queue. Completed blocks leave on a valid/ready block port that drives the core's state and key inputs.

## Interface
- NK, 4, key length in 32-bit words (4, 6 or 8)
- NR, 10, round count; only passed through for the core instance (10, 12 or 14)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_data  in  32  plaintext word
- in_valid  in  1  in_data valid
- in_last  in  1  final word of message, qualified by in_valid
- in_ready  out  1  word accepted when in_valid && in_ready
- key_data  in  32  key word (only with AES_ASM_KEY_EN)
- key_valid  in  1  key word valid (only with AES_ASM_KEY_EN)
- key_ready  out  1  key word accepted (only with AES_ASM_KEY_EN)
- key_in  in  NK*32  static key (only without AES_ASM_KEY_EN)
- key_out  out  NK*32  key for the core
- blk_out  out  128  assembled block
- blk_pad  out  1  block was zero-padded (short final block)
- blk_valid  out  1  blk_out valid
- blk_ready  in  1  core accepts block

## Operation
- A 2-bit word counter wcnt selects the lane. Word 0 goes to [127:96], word 1 to [95:64], word 2 to [63:32], word 3 to [31:0].
- A block completes in either of two cases:
  - a word is accepted with wcnt==3;
  - a word is accepted with in_last=1 at any wcnt. The remaining lanes are zero and the block's pad flag is 1 if wcnt!=3.
- On completion the block is pushed into a 2-entry FIFO and wcnt returns to 0.
- in_ready = !(fifo full && completion would occur on this word). The completion condition is wcnt==3, or in_last=1 with in_valid=1.
- Output side: blk_valid = fifo non-empty && key_loaded. A pop occurs on blk_valid && blk_ready.
- A simultaneous push and pop leaves the count unchanged. The head advances and the new block is enqueued behind it.
- Partial words already in the assembly register stay there while the FIFO is full.

## Timing
- Reset values:
  - in_ready 1, key_ready 1
  - blk_valid 0, blk_out 0, blk_pad 0, key_out 0
  - wcnt 0, fifo empty, key_loaded 0 (1 without the macro)
- Latency: blk_valid rises the cycle after the completing word is accepted, when the FIFO was empty and key_loaded=1.
- Throughput: one word per cycle sustained, one block per 4 cycles while blk_ready stays high.
- Outputs are registered. blk_out and blk_pad hold stable while blk_valid && !blk_ready.
- Reset mid-block discards all partial words, the FIFO contents and the loaded key. Outputs return to their reset values.

## Configuration
- AES_ASM_KEY_EN defined:
  - Key words are loaded through key_data/key_valid/key_ready, NK words, first word into the MSBs.
  - key_loaded sets after word NK-1.
  - key_ready = (fifo empty && wcnt==0), so the key is constant across all queued and partial blocks.
  - Loading word 0 of a new key clears key_loaded until that key is complete.
- AES_ASM_KEY_EN undefined:
  - The key_data, key_valid and key_ready ports are absent.
  - key_out = key_in, combinational.
  - key_loaded is tied to 1.

## Structure
- aes_pkg holds the shared constants and the helper:
  - constants AES_BLOCK_W=128, AES_WORD_W=32, AES_FIFO_DEPTH=2;
  - function aes_nr(nk), which returns 10, 12 or 14.
- A single sub-module, aes_blk_fifo2, implements the 2-entry, 129-bit (block + pad) FIFO with count, full and empty.

## Test plan
- Words 00112233, 44556677, 8899aabb, ccddeeff on consecutive cycles, key 000102030405060708090a0b0c0d0e0f preloaded, blk_ready=1: blk_out=00112233445566778899aabbccddeeff with blk_pad=0 one cycle after the 4th word; key_out matches the key.
- Words deadbeef, 01234567 with in_last on the second: blk_out=deadbeef012345670000000000000000, blk_pad=1, wcnt back to 0.
- blk_ready=0, feed 12 words: two blocks queue; in_ready drops on the 12th word; with blk_ready=1, the blocks pop in order and the 12th word is accepted one cycle later.
- Assert reset after two words of a block: blk_valid=0, in_ready=1; the next four words form a clean block with no stale lanes.
- With AES_ASM_KEY_EN: try a key load while a block is queued → key_ready=0. Load 8 words with NK=8 → blk_valid stays 0 until the 8th key word, then rises.
